// File: rtl/dmem_responder_pkg.sv
// Shared access-size encodings and lane helpers for the data-memory responder.
package dmem_responder_pkg;

  localparam logic [1:0] DMEM_B = 2'b00;
  localparam logic [1:0] DMEM_H = 2'b01;
  localparam logic [1:0] DMEM_W = 2'b10;
  localparam int DMEM_UNSIGNED_BIT = 2;

  // Size 11 falls through to the word case everywhere below.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      DMEM_B:  lane_be = 4'b0001 << a;
      DMEM_H:  lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      DMEM_B:  is_misaligned = 1'b0;
      DMEM_H:  is_misaligned = a[0];
      default: is_misaligned = |a;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      DMEM_B:  replicate = {4{d[7:0]}};
      DMEM_H:  replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      DMEM_B:  load_ext = uns ? {24'd0, b} : 32'(b);
      DMEM_H:  load_ext = uns ? {16'd0, h} : 32'(h);
      default: load_ext = w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, byte-enabled write and registered read.
module dmem_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// LSU-facing data-memory responder: wait-state FSM, lane/alignment logic and
// load extension in front of a byte-enabled RAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_dmem,
  input  logic        MemRd_dmem,
  input  logic        MemWr_dmem,
  input  logic [31:0] Addr_dmem,
  input  logic [31:0] data_in_dmem,
  input  logic [3:0]  Conf_dmem,
  output logic [31:0] data_out_dmem,
  output logic        stall_mem_request,
  output logic        misalign_dmem
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        misalign_q;
  logic        out_en_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        req, is_load, stall, complete, mis;
  logic [1:0]  size;
  logic [31:0] rdata;
  logic        unused_bits;

  assign req     = MemRd_dmem | MemWr_dmem;
  assign is_load = MemRd_dmem & ~MemWr_dmem;
  assign size    = Conf_dmem[1:0];
  assign mis     = is_misaligned(size, Addr_dmem[1:0]);
  assign unused_bits = ^{Addr_dmem[31:ADDR_W+2], Conf_dmem[3]};

  always_comb begin
    stall = 1'b0;
    if (!flush_dmem) begin
      case (state_q)
        S_IDLE:  stall = req & HAS_WAIT;
        S_WAIT:  stall = (cnt_q != 4'd0);
        default: stall = 1'b0;
      endcase
    end
  end

  assign stall_mem_request = stall;
  assign complete          = req & ~stall & ~flush_dmem;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (complete & MemWr_dmem & ~mis),
    .re_i    (complete & is_load),
    .be_i    (lane_be(size, Addr_dmem[1:0])),
    .addr_i  (Addr_dmem[ADDR_W+1:2]),
    .wdata_i (replicate(size, data_in_dmem)),
    .rdata_o (rdata)
  );

  // A request dropped mid-wait simply returns to IDLE without committing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      misalign_q <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      misalign_q <= complete & mis;
      if (complete & is_load) out_en_q <= ~mis;
      if (flush_dmem) begin
        state_q <= S_IDLE;
        cnt_q   <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req && HAS_WAIT) begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
          S_WAIT: begin
            if (!req || cnt_q == 4'd0) begin
              state_q <= S_IDLE;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Lane/size of the last completed load, paired with the RAM's registered read.
  always_ff @(posedge clk) begin
    if (complete & is_load) begin
      lane_q <= Addr_dmem[1:0];
      size_q <= size;
      uns_q  <= Conf_dmem[DMEM_UNSIGNED_BIT];
    end
  end

  assign data_out_dmem = out_en_q ? load_ext(rdata, size_q, lane_q, uns_q) : 32'd0;
  assign misalign_dmem = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        fl2 = 0, rd2 = 0, wr2 = 0;
  logic [31:0] addr2 = 0, din2 = 0;
  logic [3:0]  conf2 = 0;
  logic [31:0] dout2;
  logic        stall2, mis2;

  logic        fl0 = 0, rd0 = 0, wr0 = 0;
  logic [31:0] addr0 = 0, din0 = 0;
  logic [3:0]  conf0 = 0;
  logic [31:0] dout0;
  logic        stall0, mis0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(14), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .flush_dmem(fl2), .MemRd_dmem(rd2), .MemWr_dmem(wr2),
    .Addr_dmem(addr2), .data_in_dmem(din2), .Conf_dmem(conf2),
    .data_out_dmem(dout2), .stall_mem_request(stall2), .misalign_dmem(mis2)
  );

  dmem_responder #(.ADDR_W(14), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .flush_dmem(fl0), .MemRd_dmem(rd0), .MemWr_dmem(wr0),
    .Addr_dmem(addr0), .data_in_dmem(din0), .Conf_dmem(conf0),
    .data_out_dmem(dout0), .stall_mem_request(stall0), .misalign_dmem(mis0)
  );

  // Present one request to the WAIT_CYCLES=2 instance, count stall cycles,
  // and return #1 after the completion edge (the load-data cycle).
  task automatic req2(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] c, output int stalls);
    @(negedge clk);
    rd2 = rd; wr2 = wr; addr2 = a; din2 = d; conf2 = c;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!stall2) break;
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rd2 = 0; wr2 = 0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (dout2 !== 32'd0) begin n_fail++; $display("FAIL reset_dout2 got %h want %h", dout2, 32'd0); end
    n_tests++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL reset_stall2 got %b want 0", stall2); end
    n_tests++; if (mis2 !== 1'b0) begin n_fail++; $display("FAIL reset_mis2 got %b want 0", mis2); end
    n_tests++; if (dout0 !== 32'd0) begin n_fail++; $display("FAIL reset_dout0 got %h want %h", dout0, 32'd0); end
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_tests++; if (dout2 !== 32'd0) begin n_fail++; $display("FAIL post_reset_dout2 got %h want %h", dout2, 32'd0); end
  endtask

  task automatic test_word();
    int s;
    req2(0, 1, 32'h100, 32'hDEADBEEF, 4'b0010, s);
    n_tests++; if (s !== 2) begin n_fail++; $display("FAIL store_word_stalls got %0d want 2", s); end
    n_tests++; if (dout2 !== 32'd0) begin n_fail++; $display("FAIL store_dout_held got %h want %h", dout2, 32'd0); end
    req2(1, 0, 32'h100, 32'h0, 4'b0010, s);
    n_tests++; if (s !== 2) begin n_fail++; $display("FAIL load_word_stalls got %0d want 2", s); end
    n_tests++; if (dout2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_word got %h want %h", dout2, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_half();
    int s;
    req2(0, 1, 32'h101, 32'h00000080, 4'b0000, s);
    req2(1, 0, 32'h101, 32'h0, 4'b0000, s);
    n_tests++; if (dout2 !== 32'hFFFFFF80) begin n_fail++; $display("FAIL load_sbyte got %h want %h", dout2, 32'hFFFFFF80); end
    req2(1, 0, 32'h101, 32'h0, 4'b0100, s);
    n_tests++; if (dout2 !== 32'h00000080) begin n_fail++; $display("FAIL load_ubyte got %h want %h", dout2, 32'h00000080); end
    req2(1, 0, 32'h100, 32'h0, 4'b0010, s);
    n_tests++; if (dout2 !== 32'hDEAD80EF) begin n_fail++; $display("FAIL load_word_merged got %h want %h", dout2, 32'hDEAD80EF); end
    req2(1, 0, 32'h102, 32'h0, 4'b0001, s);
    n_tests++; if (dout2 !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL load_shalf got %h want %h", dout2, 32'hFFFFDEAD); end
    req2(1, 0, 32'h100, 32'h0, 4'b0101, s);
    n_tests++; if (dout2 !== 32'h000080EF) begin n_fail++; $display("FAIL load_uhalf got %h want %h", dout2, 32'h000080EF); end
    n_tests++; if (mis2 !== 1'b0) begin n_fail++; $display("FAIL aligned_mis got %b want 0", mis2); end
  endtask

  task automatic test_misalign();
    int s;
    req2(1, 0, 32'h101, 32'h0, 4'b0001, s);
    n_tests++; if (s !== 2) begin n_fail++; $display("FAIL mis_load_stalls got %0d want 2", s); end
    n_tests++; if (dout2 !== 32'd0) begin n_fail++; $display("FAIL mis_load_dout got %h want %h", dout2, 32'd0); end
    n_tests++; if (mis2 !== 1'b1) begin n_fail++; $display("FAIL mis_load_pulse got %b want 1", mis2); end
    @(posedge clk); #1;
    n_tests++; if (mis2 !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_width got %b want 0", mis2); end
    req2(0, 1, 32'h102, 32'h00000000, 4'b0010, s);
    n_tests++; if (mis2 !== 1'b1) begin n_fail++; $display("FAIL mis_store_pulse got %b want 1", mis2); end
    req2(1, 0, 32'h100, 32'h0, 4'b0010, s);
    n_tests++; if (dout2 !== 32'hDEAD80EF) begin n_fail++; $display("FAIL mis_store_suppressed got %h want %h", dout2, 32'hDEAD80EF); end
  endtask

  task automatic test_flush_reset();
    int s;
    req2(0, 1, 32'h200, 32'hCAFEF00D, 4'b0010, s);
    req2(1, 0, 32'h200, 32'h0, 4'b0010, s);
    n_tests++; if (dout2 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL prior_value got %h want %h", dout2, 32'hCAFEF00D); end
    @(negedge clk);
    wr2 = 1; addr2 = 32'h200; din2 = 32'h12345678; conf2 = 4'b0010;
    #1;
    n_tests++; if (stall2 !== 1'b1) begin n_fail++; $display("FAIL flush_stall1 got %b want 1", stall2); end
    @(negedge clk);
    fl2 = 1;
    #1;
    n_tests++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL flush_forces_stall_low got %b want 0", stall2); end
    @(posedge clk); #1;
    fl2 = 0; wr2 = 0;
    n_tests++; if (dout2 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL flush_dout_held got %h want %h", dout2, 32'hCAFEF00D); end
    req2(1, 0, 32'h200, 32'h0, 4'b0010, s);
    n_tests++; if (s !== 2) begin n_fail++; $display("FAIL after_flush_stalls got %0d want 2", s); end
    n_tests++; if (dout2 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL flush_no_commit got %h want %h", dout2, 32'hCAFEF00D); end
    @(negedge clk);
    wr2 = 1; addr2 = 32'h200; din2 = 32'h12345678; conf2 = 4'b0010;
    @(negedge clk);
    rst = 1;
    #1;
    n_tests++; if (dout2 !== 32'd0) begin n_fail++; $display("FAIL rst_mid_wait_dout got %h want %h", dout2, 32'd0); end
    n_tests++; if (stall2 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wait_restall got %b want 1", stall2); end
    @(negedge clk);
    wr2 = 0;
    #1;
    n_tests++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall2); end
    rst = 0;
    req2(1, 0, 32'h200, 32'h0, 4'b0010, s);
    n_tests++; if (dout2 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_no_commit got %h want %h", dout2, 32'hCAFEF00D); end
  endtask

  task automatic test_both_high();
    int s;
    req2(0, 1, 32'h300, 32'h00000000, 4'b0010, s);
    req2(1, 0, 32'h100, 32'h0, 4'b0010, s);
    req2(1, 1, 32'h300, 32'h00000055, 4'b0000, s);
    n_tests++; if (s !== 2) begin n_fail++; $display("FAIL both_stalls got %0d want 2", s); end
    n_tests++; if (dout2 !== 32'hDEAD80EF) begin n_fail++; $display("FAIL both_dout_held got %h want %h", dout2, 32'hDEAD80EF); end
    req2(1, 0, 32'h300, 32'h0, 4'b0010, s);
    n_tests++; if (dout2 !== 32'h00000055) begin n_fail++; $display("FAIL both_store_commit got %h want %h", dout2, 32'h00000055); end
    req2(1, 0, 32'h10300, 32'h0, 4'b0010, s);
    n_tests++; if (dout2 !== 32'h00000055) begin n_fail++; $display("FAIL alias got %h want %h", dout2, 32'h00000055); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [4];
    tbl[0] = 32'h11223344; tbl[1] = 32'hA5A5A5A5; tbl[2] = 32'h0F0F0F0F; tbl[3] = 32'h80000001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr0 = 1; rd0 = 0; addr0 = 32'(4 * i); din0 = tbl[i]; conf0 = 4'b0010;
      #1;
      n_tests++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL b2b_store_stall[%0d] got %b want 0", i, stall0); end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_tests++; if (dout0 !== tbl[i-1]) begin n_fail++; $display("FAIL b2b_load[%0d] got %h want %h", i - 1, dout0, tbl[i-1]); end
      end
      wr0 = 0;
      if (i < 4) begin
        rd0 = 1; addr0 = 32'(4 * i); conf0 = 4'b0010;
        #1;
        n_tests++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL b2b_load_stall[%0d] got %b want 0", i, stall0); end
      end else begin
        rd0 = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_flush_reset();
    test_both_high();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
